// File: rtl/mem_stage.sv
// Memory stage: byte/half/word loads and stores on a little-endian RAM,
// optional wait states, misalignment flag, single-cycle pass-through.
// Ports: clk, rst_n; valid_i/ready_o request handshake; mem_en_i, op_i,
// addr_i, store_data_i, result_i, dest_i in; valid_o, wb_en_o, wb_data_o,
// dest_o, misalign_o completion outputs.
module mem_stage #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0,
  parameter int DEST_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              mem_en_i,
  input  logic [2:0]        op_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       store_data_i,
  input  logic [31:0]       result_i,
  input  logic [DEST_W-1:0] dest_i,
  output logic              valid_o,
  output logic              wb_en_o,
  output logic [31:0]       wb_data_o,
  output logic [DEST_W-1:0] dest_o,
  output logic              misalign_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [AW+1:0]     addr;
    logic [31:0]       sdata;
    logic [DEST_W-1:0] dest;
  } req_t;

  state_t state, state_nxt;
  req_t   req;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH];

  logic accept, done;
  logic sz_b, sz_h, sz_w, sx, st;
  logic mis;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic [31:0]   word, ld_data, wd;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;

  logic              valid_nxt, wb_en_nxt, mis_nxt;
  logic [31:0]       data_nxt;
  logic [DEST_W-1:0] dest_nxt;

  logic unused_addr;
  assign unused_addr = ^addr_i[31:AW+2];

  assign ready_o = (state == IDLE);
  assign accept  = valid_i && ready_o;
  assign done    = (state == BUSY) && (cnt == 4'd0);

  // state register and captured request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= state_nxt;
      if (accept && mem_en_i) begin
        cnt   <= 4'(WAIT_STATES);
        req   <= '{op_i, addr_i[AW+1:0],
                   store_data_i, dest_i};
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && mem_en_i) state_nxt = BUSY;
      BUSY: if (done) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sz_b = 1'b0;
    sz_h = 1'b0;
    sz_w = 1'b0;
    sx   = 1'b0;
    st   = 1'b0;
    unique case (req.op)
      3'b000: begin sz_b = 1'b1; sx = 1'b1; end
      3'b001: begin sz_h = 1'b1; sx = 1'b1; end
      3'b010: sz_w = 1'b1;
      3'b011: sz_b = 1'b1;
      3'b100: sz_h = 1'b1;
      3'b101: begin sz_b = 1'b1; st = 1'b1; end
      3'b110: begin sz_h = 1'b1; st = 1'b1; end
      3'b111: begin sz_w = 1'b1; st = 1'b1; end
    endcase
  end

  assign lane   = req.addr[1:0];
  assign idx    = req.addr[AW+1:2];
  assign word   = mem[idx];
  assign byte_v = word[{lane, 3'b000} +: 8];
  assign half_v = lane[1] ? word[31:16] : word[15:0];
  assign mis    = (sz_h && lane[0]) || (sz_w && lane != 2'b00);

  always_comb begin
    ld_data = '0;
    be      = '0;
    wd      = '0;
    unique case (1'b1)
      sz_b: begin
        ld_data = {{24{sx & byte_v[7]}}, byte_v};
        be      = 4'b0001 << lane;
        wd      = {4{req.sdata[7:0]}};
      end
      sz_h: begin
        ld_data = {{16{sx & half_v[15]}}, half_v};
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wd      = {2{req.sdata[15:0]}};
      end
      sz_w: begin
        ld_data = word;
        be      = 4'b1111;
        wd      = req.sdata;
      end
    endcase
  end

  // RAM is not reset; a reset mid-op clears state so done never fires
  always_ff @(posedge clk) begin
    if (done && st && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_comb begin
    valid_nxt = 1'b0;
    wb_en_nxt = 1'b0;
    mis_nxt   = 1'b0;
    data_nxt  = wb_data_o;
    dest_nxt  = dest_o;
    if (accept && !mem_en_i) begin
      valid_nxt = 1'b1;
      data_nxt  = result_i;
      dest_nxt  = dest_i;
      wb_en_nxt = (dest_i != '0);
    end else if (done) begin
      valid_nxt = 1'b1;
      dest_nxt  = req.dest;
      mis_nxt   = mis;
      if (!mis && !st) begin
        data_nxt  = ld_data;
        wb_en_nxt = (req.dest != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      wb_en_o    <= 1'b0;
      misalign_o <= 1'b0;
      wb_data_o  <= '0;
      dest_o     <= '0;
    end else begin
      valid_o    <= valid_nxt;
      wb_en_o    <= wb_en_nxt;
      misalign_o <= mis_nxt;
      wb_data_o  <= data_nxt;
      dest_o     <= dest_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances with 0, 3 and 2 wait
// states share data inputs; each has its own valid_i.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0]  vi;
  logic        mem_en;
  logic [2:0]  op;
  logic [31:0] addr, sd, res;
  logic [4:0]  dest;

  logic [2:0]  rdy, vo, wen, mis;
  logic [31:0] wbd [3];
  logic [4:0]  dst [3];

  int vecs  = 0;
  int fails = 0;
  int n, low, early, pulses;
  int lat [3] = '{1, 4, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 3 : 2;
    mem_stage #(.DEPTH(64), .WAIT_STATES(WS), .DEST_W(5)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .valid_i(vi[g]), .ready_o(rdy[g]),
      .mem_en_i(mem_en), .op_i(op), .addr_i(addr),
      .store_data_i(sd), .result_i(res), .dest_i(dest),
      .valid_o(vo[g]), .wb_en_o(wen[g]), .wb_data_o(wbd[g]),
      .dest_o(dst[g]), .misalign_o(mis[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic issue(input int k, input logic me, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] r, input logic [4:0] de,
                       output int cyc);
    mem_en = me; op = o; addr = a; sd = d; res = r; dest = de;
    vi[k] = 1'b1;
    @(posedge clk); #1;
    vi[k] = 1'b0;
    cyc = 0;
    while (!vo[k] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic ld(input int k, input logic [2:0] o, input logic [31:0] a,
                    input logic [4:0] de, input logic [31:0] e,
                    input string tag);
    int c;
    issue(k, 1'b1, o, a, 32'h0, 32'h0, de, c);
    chk({tag, "_lat"}, c, lat[k]);
    chk(tag, wbd[k], e);
    chk({tag, "_wen"}, {31'h0, wen[k]}, 32'(de != 0));
  endtask

  task automatic st(input int k, input logic [2:0] o, input logic [31:0] a,
                    input logic [31:0] d, input string tag);
    int c;
    issue(k, 1'b1, o, a, d, 32'h0, 5'd0, c);
    chk({tag, "_lat"}, c, lat[k]);
    chk({tag, "_wen"}, {31'h0, wen[k]}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; vi = '0; mem_en = 1'b0; op = '0;
    addr = '0; sd = '0; res = '0; dest = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'h0, rdy[k]}, 32'h1);
      chk("rst_outs", {vo[k], wen[k], mis[k], dst[k], wbd[k]}, '0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // pass-through, back to back
    issue(0, 1'b0, 3'b111, 32'h0, 32'h0, 32'h12345678, 5'd3, n);
    chk("pt1_lat", n, 0);
    chk("pt1_data", wbd[0], 32'h12345678);
    chk("pt1_wen", {31'h0, wen[0]}, 32'h1);
    chk("pt1_dest", {27'h0, dst[0]}, 32'd3);
    chk("pt1_ready", {31'h0, rdy[0]}, 32'h1);
    issue(0, 1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 5'd0, n);
    chk("pt2_lat", n, 0);
    chk("pt2_data", wbd[0], 32'hCAFEF00D);
    chk("pt2_wen", {31'h0, wen[0]}, 32'h0);
    @(posedge clk); #1;
    chk("pt_idle_vo", {31'h0, vo[0]}, 32'h0);

    // word store then sub-word loads
    st(0, 3'b111, 32'h10, 32'h80FF7F01, "stw10");
    chk("stw10_hold", wbd[0], 32'hCAFEF00D);
    chk("stw10_mis", {31'h0, mis[0]}, 32'h0);
    ld(0, 3'b000, 32'h13, 5'd5, 32'hFFFFFF80, "ldb13");
    ld(0, 3'b011, 32'h12, 5'd5, 32'h000000FF, "ldbu12");
    ld(0, 3'b001, 32'h10, 5'd5, 32'h00007F01, "ldh10");
    ld(0, 3'b100, 32'h12, 5'd5, 32'h000080FF, "ldhu12");

    // byte and halfword stores into a cleared word
    st(0, 3'b111, 32'h20, 32'h00000000, "stw20");
    st(0, 3'b101, 32'h21, 32'h123456AA, "stb21");
    ld(0, 3'b010, 32'h20, 5'd4, 32'h0000AA00, "ldw20a");
    st(0, 3'b110, 32'h22, 32'h9999BEEF, "sth22");
    ld(0, 3'b010, 32'h20, 5'd4, 32'hBEEFAA00, "ldw20b");
    ld(0, 3'b001, 32'h22, 5'd4, 32'hFFFFBEEF, "ldh22");

    // misalignment, wrap-around, r0 destination
    st(0, 3'b111, 32'h30, 32'hDEADBEEF, "stw30");
    issue(0, 1'b1, 3'b001, 32'h31, 32'h0, 32'h0, 5'd6, n);
    chk("ldh31_lat", n, 1);
    chk("ldh31_flags", {29'h0, vo[0], mis[0], wen[0]}, 32'b110);
    issue(0, 1'b1, 3'b111, 32'h32, 32'h11111111, 32'h0, 5'd0, n);
    chk("stw32_flags", {29'h0, vo[0], mis[0], wen[0]}, 32'b110);
    ld(0, 3'b010, 32'h30, 5'd6, 32'hDEADBEEF, "ldw30");
    chk("ldw30_mis", {31'h0, mis[0]}, 32'h0);
    ld(0, 3'b010, 32'h130, 5'd6, 32'hDEADBEEF, "ldw_wrap");
    ld(0, 3'b010, 32'h30, 5'd0, 32'hDEADBEEF, "ldw_r0");

    // three wait states, request held across BUSY
    st(1, 3'b111, 32'h8, 32'h0BADCAFE, "ws3_st");
    mem_en = 1'b1; op = 3'b010; addr = 32'h8; dest = 5'd7;
    vi[1] = 1'b1;
    @(posedge clk); #1;
    low = 0; early = 0;
    for (int i = 0; i < 4; i++) begin
      if (!rdy[1]) low++;
      if (vo[1]) early++;
      @(posedge clk); #1;
    end
    chk("ws3_busy_cycles", low, 4);
    chk("ws3_early_vo", early, 0);
    chk("ws3_vo", {31'h0, vo[1]}, 32'h1);
    chk("ws3_data", wbd[1], 32'h0BADCAFE);
    chk("ws3_ready", {31'h0, rdy[1]}, 32'h1);
    @(posedge clk); #1;
    chk("ws3_reaccept", {30'h0, rdy[1], vo[1]}, 32'h0);
    vi[1] = 1'b0;
    n = 0;
    while (!vo[1] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ws3_second_lat", n, 4);

    // reset during a busy store
    st(2, 3'b111, 32'h40, 32'h01020304, "ws2_st");
    mem_en = 1'b1; op = 3'b111; addr = 32'h40; sd = 32'h5555AAAA;
    vi[2] = 1'b1;
    @(posedge clk); #1;
    vi[2] = 1'b0;
    chk("ws2_busy", {31'h0, rdy[2]}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("ws2_rst_outs", {vo[2], wen[2], mis[2], dst[2], wbd[2]}, '0);
    chk("ws2_rst_ready", {31'h0, rdy[2]}, 32'h1);
    chk("rst_clears_d0", {dst[0], wbd[0]}, '0);
    #3 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (vo[2]) pulses++;
    end
    chk("ws2_no_pulse", pulses, 0);
    ld(2, 3'b010, 32'h40, 5'd2, 32'h01020304, "ws2_old");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
